// File: rtl/aes256_stream_ctrl.sv
// Valid/ready and key-sequencing front end for a fixed-latency, non-stallable AES-256 core.
// Admission is credit-based so every block in the pipeline is guaranteed a slot in the output FIFO.
module aes256_stream_ctrl #(
  parameter int LATENCY    = 15,
  parameter int FIFO_DEPTH = 16,
  parameter int KEY_SETTLE = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         key_valid,
  input  logic [255:0] key_in,
  output logic         key_ready,
  input  logic         in_valid,
  input  logic [127:0] in_data,
  output logic         in_ready,
  output logic         out_valid,
  output logic [127:0] out_data,
  input  logic         out_ready,
  output logic [127:0] core_pt,
  output logic [255:0] core_key,
  input  logic [127:0] core_ct,
  output logic         busy
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int IW = $clog2(LATENCY + 1);
  localparam int TW = ((IW > CW) ? IW : CW) + 1;
  localparam int SW = (KEY_SETTLE > 1) ? $clog2(KEY_SETTLE) : 1;

  typedef enum logic [1:0] {NOKEY, RUN, DRAIN, LOAD} state_t;

  state_t             state;
  logic [LATENCY-1:0] vsr;
  logic [IW-1:0]      inflight;
  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      rd_ptr;
  logic [CW-1:0]      fifo_cnt;
  logic [255:0]       pending_key;
  logic [SW-1:0]      settle_cnt;
  logic [127:0]       mem [FIFO_DEPTH];

  logic          accept;
  logic          capture;
  logic          pop;
  logic [TW-1:0] credits_used;

  assign key_ready    = (state == NOKEY) || (state == RUN);
  assign credits_used = TW'(inflight) + TW'(fifo_cnt);
  // Only registered counts feed the credit check; a pop this cycle frees its slot next cycle.
  assign in_ready     = (state == RUN) && (credits_used < TW'(FIFO_DEPTH));
  assign accept       = in_valid && in_ready;
  assign capture      = vsr[LATENCY-1];
  assign out_valid    = (fifo_cnt != '0);
  assign pop          = out_valid && out_ready;
  assign out_data     = mem[rd_ptr];
  assign busy         = (inflight != '0) || (state != RUN);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vsr <= '0;
    end else begin
      vsr[0] <= accept;
      for (int i = 1; i < LATENCY; i++) begin
        vsr[i] <= vsr[i-1];
      end
    end
  end

  // Storage array carries no reset so it can map onto RAM; the pointers define its contents.
  always_ff @(posedge clk) begin
    if (capture) begin
      mem[wr_ptr] <= core_ct;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= NOKEY;
      inflight    <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      fifo_cnt    <= '0;
      pending_key <= '0;
      settle_cnt  <= '0;
      core_pt     <= '0;
      core_key    <= '0;
    end else begin
      if (accept) begin
        core_pt <= in_data;
      end

      if (accept && !capture) begin
        inflight <= inflight + 1'b1;
      end else if (!accept && capture) begin
        inflight <= inflight - 1'b1;
      end

      if (capture) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (capture && !pop) begin
        fifo_cnt <= fifo_cnt + 1'b1;
      end else if (!capture && pop) begin
        fifo_cnt <= fifo_cnt - 1'b1;
      end

      // LOAD lasts KEY_SETTLE cycles with core_key already updated on entry.
      case (state)
        NOKEY: begin
          if (key_valid) begin
            pending_key <= key_in;
            core_key    <= key_in;
            settle_cnt  <= '0;
            state       <= LOAD;
          end
        end
        RUN: begin
          if (key_valid) begin
            pending_key <= key_in;
            state       <= DRAIN;
          end
        end
        DRAIN: begin
          if (inflight == '0) begin
            core_key   <= pending_key;
            settle_cnt <= '0;
            state      <= LOAD;
          end
        end
        LOAD: begin
          if (settle_cnt == SW'(KEY_SETTLE - 1)) begin
            state <= RUN;
          end else begin
            settle_cnt <= settle_cnt + 1'b1;
          end
        end
        default: state <= NOKEY;
      endcase
    end
  end

endmodule

// File: tb/tb_aes256_stream_ctrl.sv
// Bench for aes256_stream_ctrl: a stub fixed-latency core plus a queue-based scoreboard
// that predicts every ciphertext from the plaintext and the key in force at its handshake.
module tb_aes256_stream_ctrl;

  localparam int LAT = 15;
  localparam int FD  = 16;
  localparam int KS  = 1;

  localparam logic [255:0] KAT_KEY = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] KAT_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] KAT_CT  = 128'h8ea2b7ca516745bfeafc49904b496089;

  logic         clk = 1'b0;
  logic         rst;
  logic         key_valid;
  logic [255:0] key_in;
  logic         key_ready;
  logic         in_valid;
  logic [127:0] in_data;
  logic         in_ready;
  logic         out_valid;
  logic [127:0] out_data;
  logic         out_ready;
  logic [127:0] core_pt;
  logic [255:0] core_key;
  logic [127:0] core_ct;
  logic         busy;

  aes256_stream_ctrl #(.LATENCY(LAT), .FIFO_DEPTH(FD), .KEY_SETTLE(KS)) dut (
    .clk(clk), .rst(rst),
    .key_valid(key_valid), .key_in(key_in), .key_ready(key_ready),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .core_pt(core_pt), .core_key(core_key), .core_ct(core_ct),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Stand-in cipher: the known-answer pair maps to the AES-256 vector, anything else to a keyed mix.
  function automatic logic [127:0] cipher(input logic [127:0] pt, input logic [255:0] key);
    if (pt == KAT_PT && key == KAT_KEY) return KAT_CT;
    return {pt[94:0], pt[127:95]} ^ key[127:0] ^ (key[255:128] + pt);
  endfunction

  // Stub core: result for the core_pt registered on edge E0 is stable before edge E0+LAT.
  logic [127:0] core_pipe [LAT-1];
  always @(posedge clk) begin
    core_pipe[0] <= cipher(core_pt, core_key);
    for (int i = 1; i < LAT - 1; i++) core_pipe[i] <= core_pipe[i-1];
  end
  assign core_ct = core_pipe[LAT-2];

  int checks = 0;
  int errors = 0;
  int n;
  int acc;
  logic [127:0] exp_q[$];
  logic [255:0] active_key;
  logic [255:0] key2;
  logic [255:0] key3;
  logic s_in_ready, s_key_ready, s_out_valid, s_hs_in, s_hs_key;
  logic [127:0] s_out_data;

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: sample 1ns after the negedge, score handshakes, advance to the next negedge.
  task automatic tick();
    #1;
    s_in_ready  = in_ready;
    s_key_ready = key_ready;
    s_out_valid = out_valid;
    s_out_data  = out_data;
    s_hs_in     = in_valid && in_ready;
    s_hs_key    = key_valid && key_ready;
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) chk("out_when_empty", 256'(out_valid), 256'd0);
      else                   chk("out_data", 256'(out_data), 256'(exp_q.pop_front()));
    end
    if (s_hs_in) exp_q.push_back(cipher(in_data, active_key));
    if (s_hs_key) active_key = key_in;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drain(input string tag);
    int k;
    k = 0;
    in_valid  = 1'b0;
    key_valid = 1'b0;
    out_ready = 1'b1;
    while ((exp_q.size() != 0 || busy) && k < 200) begin
      tick();
      k++;
    end
    chk({tag, "_empty"}, 256'(exp_q.size()), 256'd0);
    tick();
    chk({tag, "_no_extra"}, 256'(s_out_valid), 256'd0);
  endtask

  task automatic load_key(input logic [255:0] k, input string tag);
    in_valid  = 1'b0;
    key_valid = 1'b1;
    key_in    = k;
    tick();
    chk({tag, "_key_hs"}, 256'(s_hs_key), 256'd1);
    key_valid = 1'b0;
    n = 0;
    tick();
    while (!s_in_ready && n < 50) begin
      n++;
      tick();
    end
    chk({tag, "_settle"}, 256'(n), 256'(KS));
    chk({tag, "_core_key"}, core_key, k);
  endtask

  initial begin
    rst = 1'b1; key_valid = 1'b0; key_in = '0; in_valid = 1'b0; in_data = '0;
    out_ready = 1'b0; active_key = '0;
    @(negedge clk);
    chk("rst_key_ready", 256'(key_ready), 256'd1);
    chk("rst_in_ready", 256'(in_ready), 256'd0);
    chk("rst_out_valid", 256'(out_valid), 256'd0);
    chk("rst_core_pt", 256'(core_pt), 256'd0);
    chk("rst_core_key", core_key, 256'd0);
    chk("rst_busy", 256'(busy), 256'd1);
    @(negedge clk);
    rst = 1'b0;

    // No key loaded yet: plaintext must be refused and core_pt untouched.
    in_valid = 1'b1;
    in_data  = rand128();
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("nokey_in_ready", 256'(s_in_ready), 256'd0);
      chk("nokey_key_ready", 256'(s_key_ready), 256'd1);
      chk("nokey_core_pt", 256'(core_pt), 256'd0);
    end

    // Known-answer block and first-result latency.
    load_key(KAT_KEY, "kat");
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = KAT_PT;
    tick();
    chk("kat_accept", 256'(s_hs_in), 256'd1);
    in_valid = 1'b0;
    n = 0;
    do begin
      tick();
      n++;
    end while (!s_out_valid && n < 100);
    chk("kat_latency", 256'(n), 256'(LAT + 1));
    chk("kat_ct", 256'(s_out_data), 256'(KAT_CT));
    drain("kat");

    // LAT back-to-back blocks with the consumer always ready.
    out_ready = 1'b1;
    for (int i = 0; i < LAT; i++) begin
      in_valid = 1'b1;
      in_data  = rand128();
      tick();
      chk("stream_in_ready", 256'(s_in_ready), 256'd1);
    end
    in_valid = 1'b0;
    n = 0;
    while (!s_out_valid && n < 50) begin
      tick();
      n++;
    end
    chk("stream_first_out", 256'(s_out_valid), 256'd1);
    for (int i = 1; i < LAT; i++) begin
      tick();
      chk("stream_consecutive", 256'(s_out_valid), 256'd1);
    end
    drain("stream");

    // Backpressure: admission must stop at exactly FD outstanding blocks.
    out_ready = 1'b0;
    acc = 0;
    for (int i = 0; i < 40; i++) begin
      in_valid = 1'b1;
      in_data  = rand128();
      tick();
      if (s_hs_in) acc++;
    end
    chk("bp_accepts", 256'(acc), 256'(FD));
    chk("bp_in_ready_low", 256'(s_in_ready), 256'd0);
    chk("bp_out_valid", 256'(s_out_valid), 256'd1);
    drain("bp");

    // Key change offered together with the 5th in-flight block.
    key2 = {rand128(), rand128()};
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_valid  = 1'b1;
      in_data   = rand128();
      key_valid = (i == 4);
      key_in    = key2;
      tick();
      chk("kc_in_ready", 256'(s_in_ready), 256'd1);
    end
    chk("kc_key_hs", 256'(s_hs_key), 256'd1);
    key_valid = 1'b0;
    in_valid  = 1'b1;
    in_data   = rand128();
    n = 0;
    tick();
    while (!s_hs_in && n < 100) begin
      chk("kc_key_ready_low", 256'(s_key_ready), 256'd0);
      n++;
      tick();
    end
    chk("kc_stall", 256'(n), 256'(LAT + 1 + KS));
    chk("kc_core_key", core_key, key2);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_data  = rand128();
      tick();
    end
    drain("kc");

    // Asynchronous reset with blocks both in flight and queued.
    out_ready = 1'b0;
    for (int i = 0; i < 12; i++) begin
      in_valid = 1'b1;
      in_data  = rand128();
      tick();
      chk("rr_accept", 256'(s_hs_in), 256'd1);
    end
    in_valid = 1'b0;
    n = 0;
    while (!s_out_valid && n < 50) begin
      tick();
      n++;
    end
    tick();
    tick();
    chk("rr_queued", 256'(out_valid), 256'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("rr_out_valid", 256'(out_valid), 256'd0);
    chk("rr_busy", 256'(busy), 256'd1);
    chk("rr_in_ready", 256'(in_ready), 256'd0);
    chk("rr_key_ready", 256'(key_ready), 256'd1);
    chk("rr_core_key", core_key, 256'd0);
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    key3 = {rand128(), rand128()};
    load_key(key3, "rr");
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_data  = rand128();
      tick();
    end
    drain("rr");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
